// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter.
//   ram_arb_src_e  : which port a pending response belongs to
//   ram_arb_resp_t : registered response descriptor {src, err}
//   RamDataW       : RAM data bus width
package ram_arb_pkg;

    localparam int unsigned RamDataW = 32;

    typedef enum logic [1:0] {
        SrcNone,
        SrcInstr,
        SrcData
    } ram_arb_src_e;

    typedef struct packed {
        ram_arb_src_e src;
        logic         err;
    } ram_arb_resp_t;

endpackage

// File: rtl/ram_arb_addr_dec.sv
// Address window decoder: flags whether a byte address falls inside the
// RAM window [BaseAddr, BaseAddr + Depth*4).
//   addr     : byte address to test
//   in_range : 1 when addr lies inside the window
module ram_arb_addr_dec #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic [31:0] addr,
    output logic        in_range
);

    // Upper bound carried in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] Limit = {1'b0, BaseAddr} + (33'(Depth) * 33'd4);

    always_comb begin
        in_range = (addr >= BaseAddr) && ({1'b0, addr} < Limit);
    end

endmodule

// File: rtl/ram_1p_arbiter.sv
// Two-port arbiter sharing one single-port, one-cycle-latency RAM between
// the instruction-fetch and data (LSU) interfaces.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   instr_*                : fetch request (read only) and response
//   data_*                 : LSU request and response
//   ram_*                  : RAM port; ram_rdata_i valid one cycle after ram_req_o
//   stall_cnt_o            : cycles with a request left ungranted
//   conflict_cnt_o         : cycles with both ports requesting
// Optional feature: define RAM_ARB_PERF_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
module ram_1p_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned MaxStall = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                instr_req_i,
    input  logic [31:0]         instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [RamDataW-1:0] instr_rdata_o,
    output logic                instr_err_o,

    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [RamDataW-1:0] data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [RamDataW-1:0] data_rdata_o,
    output logic                data_err_o,

    output logic                ram_req_o,
    output logic                ram_we_o,
    output logic [3:0]          ram_be_o,
    output logic [31:0]         ram_addr_o,
    output logic [RamDataW-1:0] ram_wdata_o,
    input  logic [RamDataW-1:0] ram_rdata_i,

    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         conflict_cnt_o
);

    // A zero MaxStall still needs a 1-bit register; it simply never leaves 0.
    localparam int unsigned      StallW   = (MaxStall == 0) ? 1 : $clog2(MaxStall + 1);
    localparam logic [StallW-1:0] StallMax = StallW'(MaxStall);

    logic              instr_in_range;
    logic              data_in_range;
    logic              starve_hit;
    logic [StallW-1:0] starve_q;
    logic [StallW-1:0] starve_d;
    ram_arb_resp_t     resp_q;
    ram_arb_resp_t     resp_d;

    ram_arb_addr_dec #(.Depth(Depth), .BaseAddr(BaseAddr)) u_instr_dec (
        .addr     (instr_addr_i),
        .in_range (instr_in_range)
    );

    ram_arb_addr_dec #(.Depth(Depth), .BaseAddr(BaseAddr)) u_data_dec (
        .addr     (data_addr_i),
        .in_range (data_in_range)
    );

    always_comb begin
        starve_hit  = (MaxStall != 0) && (starve_q == StallMax);
        instr_gnt_o = instr_req_i && (!data_req_i || starve_hit);
        data_gnt_o  = data_req_i && !instr_gnt_o;

        // Data payload is the idle default on the RAM port.
        ram_req_o   = data_gnt_o && data_in_range;
        ram_we_o    = data_gnt_o && data_in_range && data_we_i;
        ram_be_o    = data_be_i;
        ram_addr_o  = data_addr_i;
        ram_wdata_o = data_wdata_i;
        resp_d.src  = SrcNone;
        resp_d.err  = 1'b0;

        if (instr_gnt_o) begin
            ram_req_o  = instr_in_range;
            ram_we_o   = 1'b0;
            ram_be_o   = 4'hF;
            ram_addr_o = instr_addr_i;
            resp_d.src = SrcInstr;
            resp_d.err = !instr_in_range;
        end else if (data_gnt_o) begin
            resp_d.src = SrcData;
            resp_d.err = !data_in_range;
        end

        starve_d = starve_q;
        if (instr_gnt_o) begin
            starve_d = '0;
        end else if (instr_req_i && (starve_q != StallMax)) begin
            starve_d = starve_q + StallW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q.src <= SrcNone;
            resp_q.err <= 1'b0;
            starve_q   <= '0;
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        instr_rvalid_o = (resp_q.src == SrcInstr);
        instr_err_o    = instr_rvalid_o && resp_q.err;
        instr_rdata_o  = (instr_rvalid_o && !resp_q.err) ? ram_rdata_i : '0;
        data_rvalid_o  = (resp_q.src == SrcData);
        data_err_o     = data_rvalid_o && resp_q.err;
        data_rdata_o   = (data_rvalid_o && !resp_q.err) ? ram_rdata_i : '0;
    end

`ifdef RAM_ARB_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] conflict_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (((instr_req_i && !instr_gnt_o) || (data_req_i && !data_gnt_o)) &&
                (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (instr_req_i && data_req_i && (conflict_q != '1)) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o    = stall_q;
    assign conflict_cnt_o = conflict_q;
`else
    assign stall_cnt_o    = '0;
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Directed self-checking bench for ram_1p_arbiter with a behavioural
// one-cycle-latency RAM attached to the arbiter's RAM port.
module tb_ram_1p_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        ram_req_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic [31:0] stall_cnt_o, conflict_cnt_o;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    always #5 clk_i = ~clk_i;

    ram_1p_arbiter #(.Depth(128), .BaseAddr(32'h0), .MaxStall(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .ram_req_o      (ram_req_o),
        .ram_we_o       (ram_we_o),
        .ram_be_o       (ram_be_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i),
        .stall_cnt_o    (stall_cnt_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    // Behavioural RAM: preset contents on reset, byte-enabled writes.
    logic [31:0] mem [128];
    logic [31:0] rdata_q;
    assign ram_rdata_i = rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            mem[4]  <= 32'hDEAD_BEEF;
            mem[8]  <= 32'hFFFF_FFFF;
            rdata_q <= '0;
        end else if (ram_req_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o[8:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end else begin
                rdata_q <= mem[ram_addr_o[8:2]];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                         input logic [31:0] dwdata);
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = daddr;
        data_wdata_i = dwdata;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    logic [31:0] exp_perf;

    initial begin
        // Reset state
        idle();
        tick(); tick();
        check_eq("rst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'd0);
        check_eq("rst_data_rvalid",  {31'b0, data_rvalid_o},  32'd0);
        check_eq("rst_instr_rdata",  instr_rdata_o, 32'd0);
        check_eq("rst_stall_cnt",    stall_cnt_o, 32'd0);
        check_eq("rst_conflict_cnt", conflict_cnt_o, 32'd0);
        rst_i = 1'b0;
        tick();
        check_eq("post_rst_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);

        // Fetch only from word 4
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check_eq("fetch_gnt",     {30'b0, instr_gnt_o, data_gnt_o}, 32'h2);
        check_eq("fetch_ram_req", {29'b0, ram_req_o, ram_we_o, 1'b0}, 32'h4);
        check_eq("fetch_ram_be",  {28'b0, ram_be_o}, 32'hF);
        check_eq("fetch_ram_addr", ram_addr_o, 32'h10);
        tick();
        idle();
        check_eq("fetch_rvalid", {29'b0, instr_rvalid_o, instr_err_o, data_rvalid_o}, 32'h4);
        check_eq("fetch_rdata",  instr_rdata_o, 32'hDEAD_BEEF);

        // Partial write over 0xFFFFFFFF then read back
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234_5678);
        #1;
        check_eq("wr_gnt",    {30'b0, instr_gnt_o, data_gnt_o}, 32'h1);
        check_eq("wr_ram",    {30'b0, ram_req_o, ram_we_o}, 32'h3);
        check_eq("wr_ram_be", {28'b0, ram_be_o}, 32'h3);
        tick();
        check_eq("wr_rvalid", {30'b0, data_rvalid_o, data_err_o}, 32'h2);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        tick();
        idle();
        check_eq("rd_back", data_rdata_o, 32'hFFFF_5678);

        // Last in-range word, then first out-of-range word
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1FC, 32'h0);
        #1;
        check_eq("edge_in_ram_req", {31'b0, ram_req_o}, 32'd1);
        tick();
        check_eq("edge_in_err", {30'b0, data_rvalid_o, data_err_o}, 32'h2);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        #1;
        check_eq("oor_gnt_ramreq", {30'b0, data_gnt_o, ram_req_o}, 32'h2);
        tick();
        idle();
        check_eq("oor_resp",  {30'b0, data_rvalid_o, data_err_o}, 32'h3);
        check_eq("oor_rdata", data_rdata_o, 32'h0);

        // Data then fetch, back to back
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        tick();
        drive(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_eq("alt_d_rdata",    data_rdata_o, 32'hDEAD_BEEF);
        check_eq("alt_d_ivalid",   {31'b0, instr_rvalid_o}, 32'd0);
        check_eq("alt_d_irdata",   instr_rdata_o, 32'h0);
        tick();
        idle();
        check_eq("alt_i_rdata",  instr_rdata_o, 32'hFFFF_5678);
        check_eq("alt_i_dvalid", {31'b0, data_rvalid_o}, 32'd0);
        check_eq("alt_i_drdata", data_rdata_o, 32'h0);

        // Starvation guard: both request continuously for 10 cycles
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            check_eq($sformatf("starve_gnt_%0d", k), {30'b0, instr_gnt_o, data_gnt_o},
                     ((k % 5) == 4) ? 32'h2 : 32'h1);
            tick();
            check_eq($sformatf("starve_route_%0d", k), {30'b0, instr_rvalid_o, data_rvalid_o},
                     ((k % 5) == 4) ? 32'h2 : 32'h1);
        end
        idle();
`ifdef RAM_ARB_PERF_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        check_eq("conflict_cnt", conflict_cnt_o, exp_perf);
        check_eq("stall_cnt",    stall_cnt_o,    exp_perf);

        // Reset right after a grant; build up some starvation first
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        tick(); tick();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        idle();
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        check_eq("rst_mid_rdata",  instr_rdata_o, 32'h0);
        tick();
        rst_i = 1'b0;
        tick();
        check_eq("rst_rel_rvalid",   {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        check_eq("rst_rel_stall",    stall_cnt_o, 32'h0);
        check_eq("rst_rel_conflict", conflict_cnt_o, 32'h0);

        // Build starvation, reset, and confirm the counter restarted from zero
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        tick(); tick(); tick();
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("rst_starve_gnt_%0d", k), {31'b0, instr_gnt_o},
                     (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_1p_arbiter.md
# ram_1p_arbiter

Two-requester arbiter that shares one single-port, one-cycle-latency 32-bit RAM between the Ibex instruction-fetch and data (LSU) interfaces on the Arty A7 top. It grants at most one request per cycle, drives the RAM port, routes the next-cycle read data back to the granted requester, and flags accesses outside the RAM window. Data requests have fixed priority over fetches, with a bounded-starvation guard for the fetch port.

## Interface
- `Depth`, 128: RAM depth in 32-bit words; power of two.
- `BaseAddr`, 32'h0000_0000: byte address of word 0; aligned to Depth*4.
- `MaxStall`, 4: consecutive denied fetch cycles before fetch wins; 0 disables the guard.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `instr_req_i` in 1, `instr_addr_i` in 32: fetch request; always a read.
- `instr_gnt_o` out 1, `instr_rvalid_o` out 1, `instr_rdata_o` out 32, `instr_err_o` out 1: fetch grant and response.
- `data_req_i` in 1, `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32: LSU request.
- `data_gnt_o` out 1, `data_rvalid_o` out 1, `data_rdata_o` out 32, `data_err_o` out 1: LSU grant and response.
- `ram_req_o` out 1, `ram_we_o` out 1, `ram_be_o` out 4, `ram_addr_o` out 32, `ram_wdata_o` out 32: RAM port.
- `ram_rdata_i` in 32: RAM read data, valid one cycle after `ram_req_o`.
- `stall_cnt_o` out 32, `conflict_cnt_o` out 32: performance counters (see Configuration).

## Operation
- A request is in range iff `BaseAddr <= addr < BaseAddr + Depth*4`, compared as 32-bit unsigned values.
- Requesters hold `req` and its payload until they see `gnt`; `gnt` is combinational from the same-cycle `req`.
- Arbitration each cycle:
  - only one port requesting: that port is granted;
  - both requesting: data is granted, unless `MaxStall != 0` and `starve_q == MaxStall`, in which case fetch is granted.
- `starve_q` (width $clog2(MaxStall+1)):
  - increments, saturating at `MaxStall`, on each cycle with `instr_req_i && !instr_gnt_o`;
  - clears on any fetch grant;
  - holds otherwise.
- Granted in-range request: `ram_req_o=1`, payload forwarded. For fetch, `ram_we_o=0` and `ram_be_o=4'hF`.
- Granted out-of-range request: grant is still given, `ram_req_o=0`, and an error response is scheduled.
- When nothing is granted: `ram_req_o=0` and `ram_we_o=0`; the other RAM outputs carry the data-port payload (don't care).
- Response register `resp_q = {src (None/Instr/Data), err}` is loaded every cycle from the grant decision.
- Cycle after a grant: the selected port's `rvalid=1` and `err=resp_q.err`.
  - `rdata = ram_rdata_i` when err=0; `rdata = 0` when err=1.
  - Writes also return `rvalid`, with rdata don't care.
- Non-selected port: `rvalid=0`, `err=0`, `rdata=0`.
- Simultaneous new grant and pending response in the same cycle are independent (full throughput: one access per cycle).

## Timing
- Grant latency 0 cycles; response latency exactly 1 cycle after grant; no back-pressure on responses.
- Reset values: `resp_q.src=None`, `resp_q.err=0`, `starve_q=0`, counters 0. Hence all `rvalid`, `err` and `rdata` outputs are 0 during and after reset until a new grant.
- Reset mid-operation discards any pending response; no `rvalid` is produced for a request granted in the cycle reset asserts.
- Combinational `gnt` and `ram_*` outputs follow their inputs even while reset is asserted; requesters must not issue requests during reset.

## Configuration
- `RAM_ARB_PERF_EN` defined:
  - `stall_cnt_o` increments on every cycle where some `req` is high without its `gnt`;
  - `conflict_cnt_o` increments on every cycle where both `req` are high;
  - both are 32-bit, saturating at 32'hFFFF_FFFF, and reset to 0.
- `RAM_ARB_PERF_EN` undefined: no counter flops; both outputs are tied to 32'h0.

## Structure
- Package `ram_arb_pkg` holds:
  - enum `ram_arb_src_e` {SrcNone, SrcInstr, SrcData};
  - struct `ram_arb_resp_t` {src, err};
  - the width of the RAM data bus (32).
- Sub-module `ram_arb_addr_dec` (parameters `Depth`, `BaseAddr`; input addr; output `in_range`) is instantiated once per port.

## Test plan
- Fetch only, `instr_addr=0x10`, RAM word 4 = 0xDEADBEEF -> `instr_gnt=1` same cycle; next cycle `instr_rvalid=1`, `instr_rdata=0xDEADBEEF`, `instr_err=0`.
- Both request every cycle, `MaxStall=4` -> data granted 4 consecutive cycles, fetch granted in the 5th; pattern repeats; `conflict_cnt_o=10` after 10 cycles with PERF_EN.
- Data write `addr=0x20`, `be=4'b0011`, `wdata=0x12345678` over 0xFFFFFFFF, then read back -> 0xFFFF5678.
- `data_addr=0x200` with `Depth=128` -> `gnt=1`, `ram_req_o=0`; next cycle `data_rvalid=1`, `data_err=1`, `data_rdata=0`.
- Alternate grants back-to-back (data then fetch) -> responses are routed to the correct ports in consecutive cycles with no cross-talk.
- Assert `rst_i` in the cycle after a grant -> no `rvalid` on either port; `starve_q` and counters read 0 after reset release.
